ext_mem_loader: RTL

//  Host-side initiator for the cpu external memory ports (*_ext to IMEM, *_ext_2 to DMEM).

---
 rtl/ext_mem_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ext_mem_loader.sv
// Host-side loader: streams words into IMEM/DMEM ext ports, dumps DMEM, runs the CPU.
// Optional running checksum of transferred words when LOADER_CHECKSUM_EN is defined.
module ext_mem_loader #(
    parameter int ADDR_W      = 64,
    parameter int LEN_W       = 16,
    parameter int IMEM_STRIDE = 4,
    parameter int DMEM_STRIDE = 8
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [63:0]       din_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [63:0]       dout_data,
    output logic              done,
    output logic              cpu_enable,
    output logic [ADDR_W-1:0] addr_ext,
    output logic              wen_ext,
    output logic [31:0]       wdata_ext,
    output logic [ADDR_W-1:0] addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [63:0]       wdata_ext_2,
    input  logic [63:0]       rdata_ext_2
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [63:0]       checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DUMP_RD,
        S_DUMP_WAIT,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_LOAD_I = 2'b00;
    localparam logic [1:0] OP_LOAD_D = 2'b01;
    localparam logic [1:0] OP_DUMP_D = 2'b10;
    localparam logic [1:0] OP_RUN    = 2'b11;

    localparam logic [ADDR_W-1:0] I_STEP = ADDR_W'(IMEM_STRIDE);
    localparam logic [ADDR_W-1:0] D_STEP = ADDR_W'(DMEM_STRIDE);
    localparam logic [LEN_W-1:0]  ONE    = LEN_W'(1);

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       dout_q, dout_d;
    logic              hold_q, hold_d;
    logic [63:0]       csum_q, csum_d;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            hold_q  <= 1'b0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            hold_q  <= hold_d;
            csum_q  <= csum_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        hold_d      = hold_q;
        csum_d      = csum_q;
        cmd_ready   = 1'b0;
        din_ready   = 1'b0;
        dout_valid  = 1'b0;
        dout_data   = '0;
        done        = 1'b0;
        cpu_enable  = 1'b0;
        addr_ext    = '0;
        wen_ext     = 1'b0;
        wdata_ext   = '0;
        addr_ext_2  = '0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        wdata_ext_2 = '0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    ptr_d  = cmd_addr;
                    cnt_d  = cmd_len;
                    csum_d = '0;
                    if (cmd_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        unique case (cmd_op)
                            OP_LOAD_I: state_d = S_LOAD;
                            OP_LOAD_D: state_d = S_LOAD;
                            OP_DUMP_D: state_d = S_DUMP_RD;
                            OP_RUN:    state_d = S_RUN;
                            default:   state_d = S_IDLE;
                        endcase
                    end
                end
            end
            S_LOAD: begin
                din_ready = 1'b1;
                if (op_q == OP_LOAD_I) begin
                    addr_ext  = ptr_q;
                    wdata_ext = din_data[31:0];
                    wen_ext   = din_valid;
                end else begin
                    addr_ext_2  = ptr_q;
                    wdata_ext_2 = din_data;
                    wen_ext_2   = din_valid;
                end
                if (din_valid) begin
                    if (op_q == OP_LOAD_I) begin
                        ptr_d  = ptr_q + I_STEP;
                        csum_d = csum_q + {32'b0, din_data[31:0]};
                    end else begin
                        ptr_d  = ptr_q + D_STEP;
                        csum_d = csum_q + din_data;
                    end
                    cnt_d = cnt_q - ONE;
                    if (cnt_q == ONE) state_d = S_DONE;
                end
            end
            S_DUMP_RD: begin
                ren_ext_2  = 1'b1;
                addr_ext_2 = ptr_q;
                hold_d     = 1'b0;
                state_d    = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                // Read data is live only in the first wait cycle; hold it after that.
                dout_valid = 1'b1;
                dout_data  = hold_q ? dout_q : rdata_ext_2;
                if (!hold_q) begin
                    dout_d = rdata_ext_2;
                    hold_d = 1'b1;
                end
                if (dout_ready) begin
                    hold_d  = 1'b0;
                    ptr_d   = ptr_q + D_STEP;
                    cnt_d   = cnt_q - ONE;
                    csum_d  = csum_q + dout_data;
                    state_d = (cnt_q == ONE) ? S_DONE : S_DUMP_RD;
                end
            end
            S_RUN: begin
                cpu_enable = 1'b1;
                cnt_d      = cnt_q - ONE;
                if (cnt_q == ONE) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef LOADER_CHECKSUM_EN
    assign checksum = csum_q;
`else
    logic unused_csum;
    assign unused_csum = ^csum_q;
`endif

endmodule
